// File: rtl/buzzer_note_sequencer.sv
// Note-table player: walks a synchronous note ROM and drives ax_pwm period/duty words.
// Optional BUZZER_SEQ_LOOP_EN makes the song repeat instead of stopping at its end.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | silent, waiting for start
// FETCH | note_addr just changed, ROM read in flight
// LOAD  | ROM data valid: latch note words or detect end-of-song
// PLAY  | holding the current note for note_len * TICK_CYCLES cycles
module buzzer_note_sequencer #(
  parameter int            N           = 32,
  parameter int            AW          = 4,
  parameter int            TICK_CYCLES = 5_000_000,
  parameter logic [N-1:0]  DUTY_ON     = {1'b1, {(N-1){1'b0}}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  output logic [AW-1:0] note_addr,
  input  logic [N-1:0]  note_period,
  input  logic [7:0]    note_len,
  output logic [N-1:0]  pwm_period,
  output logic [N-1:0]  pwm_duty,
  output logic          busy,
  output logic          done
);

  localparam int            TW        = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_LAST = '1;

`ifdef BUZZER_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    len_cnt;
  logic [7:0]    len_q;
  logic          note_done;
  logic          song_end;
  logic          loop_again;

  assign note_done = (state == PLAY) && (tick_cnt == TICK_LAST) && (len_cnt == len_q - 8'd1);
  assign song_end  = ((state == LOAD) && (note_len == 8'd0)) ||
                     (note_done && (note_addr == ADDR_LAST));
  // An end marker at address 0 would loop on silence forever, so it always ends play.
  assign loop_again = LOOP_EN && !((state == LOAD) && (note_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      note_addr  <= '0;
      pwm_period <= '0;
      pwm_duty   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tick_cnt   <= '0;
      len_cnt    <= '0;
      len_q      <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        busy       <= 1'b0;
        note_addr  <= '0;
        pwm_period <= '0;
        pwm_duty   <= '0;
        tick_cnt   <= '0;
        len_cnt    <= '0;
      end else if (start) begin
        state     <= FETCH;
        busy      <= 1'b1;
        note_addr <= '0;
        tick_cnt  <= '0;
        len_cnt   <= '0;
      end else if (song_end) begin
        pwm_period <= '0;
        pwm_duty   <= '0;
        note_addr  <= '0;
        tick_cnt   <= '0;
        len_cnt    <= '0;
        done       <= 1'b1;
        if (loop_again) begin
          state <= FETCH;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          FETCH: begin
            state <= LOAD;
          end
          LOAD: begin
            pwm_period <= note_period;
            pwm_duty   <= (note_period == '0) ? '0 : DUTY_ON;
            len_q      <= note_len;
            tick_cnt   <= '0;
            len_cnt    <= '0;
            state      <= PLAY;
          end
          PLAY: begin
            if (note_done) begin
              note_addr <= note_addr + AW'(1);
              tick_cnt  <= '0;
              len_cnt   <= '0;
              state     <= FETCH;
            end else if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              len_cnt  <= len_cnt + 8'd1;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_note_sequencer.sv
// Bench for buzzer_note_sequencer: per-cycle expected output trace queued from a song-level
// generator and compared each cycle; honours BUZZER_SEQ_LOOP_EN.
module tb_buzzer_note_sequencer;

  localparam int          TC   = 4;
  localparam logic [31:0] DUTY = 32'h8000_0000;
`ifdef BUZZER_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef logic [67:0] obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  note_addr;
  logic [31:0] note_period;
  logic [7:0]  note_len;
  logic [31:0] pwm_period;
  logic [31:0] pwm_duty;
  logic        busy;
  logic        done;

  logic [31:0] rom_p [4];
  logic [7:0]  rom_l [4];
  obs_t        exp_q [$];
  obs_t        obs;
  obs_t        e;
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  buzzer_note_sequencer #(.N(32), .AW(2), .TICK_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .note_addr(note_addr), .note_period(note_period), .note_len(note_len),
    .pwm_period(pwm_period), .pwm_duty(pwm_duty), .busy(busy), .done(done)
  );

  always_ff @(posedge clk) begin
    note_period <= rom_p[note_addr];
    note_len    <= rom_l[note_addr];
  end

  assign obs = {pwm_period, pwm_duty, busy, done, note_addr};

  task automatic push(input logic [31:0] p, input logic [31:0] d, input logic b,
                      input logic dn, input logic [1:0] a);
    exp_q.push_back({p, d, b, dn, a});
  endtask

  // Expected trace from the cycle after start is sampled, song-level view of the ROM.
  task automatic gen_song(input logic [31:0] hp, input logic [31:0] hd, input int passes);
    logic [31:0] cp, cd;
    int a, gap, pass;
    bit fin, spin;
    cp = hp; cd = hd; a = 0; gap = 2; pass = 0; fin = 1'b0;
    while (!fin) begin
      repeat (gap) push(cp, cd, 1'b1, 1'b0, a[1:0]);
      gap = 2;
      if (rom_l[a] != 8'd0) begin
        cp = rom_p[a];
        cd = (rom_p[a] == 32'd0) ? 32'd0 : DUTY;
        repeat (int'(rom_l[a]) * TC) push(cp, cd, 1'b1, 1'b0, a[1:0]);
      end
      if (rom_l[a] == 8'd0 || a == 3) begin
        spin = LOOP && !(rom_l[a] == 8'd0 && a == 0);
        pass++;
        push(32'd0, 32'd0, spin, 1'b1, 2'd0);
        cp = 32'd0; cd = 32'd0; a = 0; gap = 1;
        fin = !spin || pass >= passes;
      end else begin
        a++;
      end
    end
  endtask

  task automatic load_rom_song;
    rom_p[0] = 32'd100; rom_l[0] = 8'd2;
    rom_p[1] = 32'd0;   rom_l[1] = 8'd1;
    rom_p[2] = 32'd300; rom_l[2] = 8'd1;
    rom_p[3] = 32'd999; rom_l[3] = 8'd0;
  endtask

  task automatic load_rom_len1;
    for (int i = 0; i < 4; i++) begin
      rom_p[i] = 32'(10 * (i + 1));
      rom_l[i] = 8'd1;
    end
  endtask

  task automatic test_reset;
    int cyc;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    #3;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_initial got %h want %h", obs, obs_t'(0));
    end
    @(negedge clk) rst = 1'b0;
    load_rom_len1();
    start = 1'b1;
    gen_song(32'd0, 32'd0, 1);
    for (cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_run cyc %0d got %h want %h", cyc, obs, e);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_async got %h want %h", obs, obs_t'(0));
    end
    @(negedge clk) rst = 1'b0;
    exp_q.delete();
    repeat (3) push(32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_idle got %h want %h", obs, e);
      end
    end
  endtask

  task automatic test_song;
    int cyc;
    load_rom_song();
    @(negedge clk) start = 1'b1;
    gen_song(32'd0, 32'd0, 1);
    for (int pass = 0; pass < 2; pass++) begin
      cyc = 0;
      while (exp_q.size() != 0) begin
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL song phase %0d cyc %0d got %h want %h", pass, cyc, obs, e);
        end
        cyc++;
      end
      if (pass == 0) begin
        stop = 1'b1;
        repeat (3) push(32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
      end
    end
  endtask

  task automatic test_all_len1;
    int cyc;
    load_rom_len1();
    @(negedge clk) start = 1'b1;
    gen_song(32'd0, 32'd0, 1);
    for (int pass = 0; pass < 2; pass++) begin
      cyc = 0;
      while (exp_q.size() != 0) begin
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL len1 phase %0d cyc %0d got %h want %h", pass, cyc, obs, e);
        end
        cyc++;
      end
      if (pass == 0) begin
        stop = 1'b1;
        repeat (3) push(32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
      end
    end
  endtask

  task automatic test_stop;
    int cyc;
    load_rom_len1();
    for (int run = 0; run < 2; run++) begin
      @(negedge clk) start = 1'b1;
      exp_q.delete();
      gen_song(32'd0, 32'd0, 1);
      for (cyc = 0; cyc < 10; cyc++) begin
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL stop_run %0d cyc %0d got %h want %h", run, cyc, obs, e);
        end
      end
      stop = 1'b1;
      start = (run == 1);
      exp_q.delete();
      repeat (4) push(32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
      cyc = 0;
      while (exp_q.size() != 0) begin
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL stop_idle %0d cyc %0d got %h want %h", run, cyc, obs, e);
        end
        cyc++;
      end
    end
  endtask

  task automatic test_restart;
    int cyc;
    load_rom_len1();
    @(negedge clk) start = 1'b1;
    exp_q.delete();
    gen_song(32'd0, 32'd0, 1);
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL restart_pre cyc %0d got %h want %h", cyc, obs, e);
      end
    end
    start = 1'b1;
    exp_q.delete();
    gen_song(32'd20, DUTY, 1);
    for (int pass = 0; pass < 2; pass++) begin
      cyc = 0;
      while (exp_q.size() != 0) begin
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL restart phase %0d cyc %0d got %h want %h", pass, cyc, obs, e);
        end
        cyc++;
      end
      if (pass == 0) begin
        stop = 1'b1;
        repeat (3) push(32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
      end
    end
  endtask

  task automatic test_loop;
    int cyc;
    int done_seen;
`ifdef BUZZER_SEQ_LOOP_EN
    load_rom_song();
    @(negedge clk) start = 1'b1;
    exp_q.delete();
    gen_song(32'd0, 32'd0, 3);
    done_seen = 0;
    cyc = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      done_seen += int'(done);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL loop3 cyc %0d got %h want %h", cyc, obs, e);
      end
      cyc++;
    end
    checks++;
    if (done_seen != 3) begin
      errors++;
      $display("FAIL loop_done_count got %0d want 3", done_seen);
    end
    stop = 1'b1;
    repeat (3) push(32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      stop = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL loop_stop got %h want %h", obs, e);
      end
    end
`endif
    rom_p[0] = 32'd50; rom_l[0] = 8'd0;
    @(negedge clk) start = 1'b1;
    exp_q.delete();
    gen_song(32'd0, 32'd0, 1);
    repeat (3) push(32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
    cyc = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL marker0 cyc %0d got %h want %h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    load_rom_song();
    test_reset();
    test_song();
    test_all_len1();
    test_stop();
    test_restart();
    test_loop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
